// File: rtl/mem_lsu.sv
// Load/store initiator for the word-wide memory bus: byte-lane masking, store replication, load extension, timeout.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word requests into error responses with no bus access.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          write_q, uns_q, err_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          req_bad, timeout;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_ext;

  // Request-side errors skip the bus entirely and go straight to RESP.
  always_comb begin
    req_bad = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])
      req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
`else
    req_bad = req_bad;
`endif
  end

  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    mem_rstrobe = 1'b0;
    mem_wstrobe = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_rstrobe = !write_q;
        mem_wstrobe = write_q;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (mem_done || timeout)
          state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane selection uses only the offset bits meaningful for the access size.
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            uns_q   <= req_unsigned;
            err_q   <= req_bad;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'b0;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_done) begin
            if (!write_q)
              rdata_q <= load_ext;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_error = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? rdata_q : 32'b0;

  always_comb begin
    case (size_q)
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
  end

  // Byte enables are only presented while a store is on the bus.
  always_comb begin
    mem_wmask = 4'b0000;
    if (write_q && (state == ISSUE || state == WAIT)) begin
      case (size_q)
        2'b00:   mem_wmask = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wmask = 4'b0011 << {addr_q[1], 1'b0};
        default: mem_wmask = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: behavioural responder plus a byte-level reference model of memory and load/store rules.
module tb_mem_lsu;

  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrobe, mem_rstrobe, mem_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  // Reference rules expressed as plain arithmetic on addresses and values.
  function automatic bit model_err(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (TRAP && sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (TRAP && sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_mask(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] a, logic [1:0] sz, logic un);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (word >> (8 * (a % 4))) & 32'hFF;
      if (!un && v >= 128) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!un && v >= 32768) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic model_store(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int i;
    int sh;
    i = int'(a[7:2]);
    if (sz == 2'd0) begin
      sh = int'(a % 4) * 8;
      ref_mem[i][sh +: 8] = wd[7:0];
    end else if (sz == 2'd1) begin
      sh = int'((a / 2) % 2) * 16;
      ref_mem[i][sh +: 16] = wd[15:0];
    end else begin
      ref_mem[i] = wd;
    end
  endtask

  // Drives one request from the current cycle (cycle 0), acts as the bus responder
  // (done lat cycles after the strobe, lat=0 means never), and reports what was seen.
  task automatic run_access(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic un, input logic [31:0] wd, input int lat, input bit stale,
                            output int resp_cyc, output logic [31:0] r_data, output logic r_err,
                            output int n_stb, output int stb_cyc, output logic stb_w,
                            output logic [3:0] stb_mask, output logic [31:0] stb_wdata,
                            output logic [31:0] stb_addr, output logic ready_after);
    int done_cyc;
    int idx;
    resp_cyc = -1; r_data = 32'b0; r_err = 1'b0; n_stb = 0; stb_cyc = -1; stb_w = 1'b0;
    stb_mask = 4'b0; stb_wdata = 32'b0; stb_addr = 32'b0; ready_after = 1'b0; done_cyc = -1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_unsigned = un; req_wdata = wd; mem_done = 1'b0;
    for (int cyc = 1; cyc <= 40 && resp_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_wdata = $urandom;
      mem_done = 1'b0; mem_rdata = $urandom;
      if (mem_rstrobe || mem_wstrobe) begin
        n_stb++; stb_cyc = cyc; stb_w = mem_wstrobe; stb_mask = mem_wmask;
        stb_wdata = mem_wdata; stb_addr = mem_addr;
        if (lat > 0) done_cyc = cyc + lat;
      end
      if (resp_valid) begin
        resp_cyc = cyc; r_data = resp_rdata; r_err = resp_error; req_valid = 1'b0;
      end else begin
        if (cyc == done_cyc) begin
          mem_done = 1'b1;
          idx = int'(stb_addr[7:2]);
          if (stb_w) begin
            for (int k = 0; k < 4; k++)
              if (stb_mask[k]) bus_mem[idx][8*k +: 8] = stb_wdata[8*k +: 8];
          end else begin
            mem_rdata = bus_mem[idx];
          end
        end
        if (stale && cyc == 1) mem_done = 1'b1;
      end
    end
    req_valid = 1'b0; mem_done = 1'b0;
    @(posedge clk); #1;
    ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom;
      req_size = 2'($urandom); req_wdata = $urandom; mem_done = 1'($urandom);
    end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset req_ready: got %b expected 1", req_ready); end
    checks++; if ({resp_valid, resp_error} !== 2'b00) begin errors++; $display("[TB] FAIL reset resp flags: got %b expected 00", {resp_valid, resp_error}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({mem_wmask, mem_wstrobe, mem_rstrobe} !== 6'b0) begin errors++; $display("[TB] FAIL reset mask/strobes: got %b expected 0", {mem_wmask, mem_wstrobe, mem_rstrobe}); end
    req_valid = 1'b0; mem_done = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed();
    int rc, ns, sc; logic [31:0] rd, sw, sa; logic re, sww, ra; logic [3:0] sm;
    run_access(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    model_store(32'h10, 2'd2, 32'hDEADBEEF);
    checks++; if ({sc, sww} !== {32'sd1, 1'b1}) begin errors++; $display("[TB] FAIL wstore strobe: got cycle %0d w=%b expected cycle 1 w=1", sc, sww); end
    checks++; if (sm !== 4'b1111) begin errors++; $display("[TB] FAIL wstore mask: got %b expected 1111", sm); end
    checks++; if (sa !== 32'h10) begin errors++; $display("[TB] FAIL wstore addr: got %h expected 00000010", sa); end
    checks++; if ({rc, re} !== {32'sd3, 1'b0}) begin errors++; $display("[TB] FAIL wstore resp: got cycle %0d err=%b expected cycle 3 err=0", rc, re); end
    run_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wload data: got %h expected deadbeef", rd); end

    bus_mem[4] = 32'h0; ref_mem[4] = 32'h0;
    run_access(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    model_store(32'h13, 2'd0, 32'h000000A5);
    checks++; if (sm !== 4'b1000) begin errors++; $display("[TB] FAIL bstore mask: got %b expected 1000", sm); end
    checks++; if (sw !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL bstore wdata: got %h expected a5a5a5a5", sw); end
    run_access(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rd !== 32'hFFFFFFA5) begin errors++; $display("[TB] FAIL bload signed: got %h expected ffffffa5", rd); end
    run_access(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 2, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rd !== 32'h000000A5) begin errors++; $display("[TB] FAIL bload unsigned: got %h expected 000000a5", rd); end

    bus_mem[8] = 32'h80017FFF; ref_mem[8] = 32'h80017FFF;
    run_access(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL hload 0x22: got %h expected ffff8001", rd); end
    run_access(1'b0, 32'h20, 2'd1, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rd !== 32'h00007FFF) begin errors++; $display("[TB] FAIL hload 0x20: got %h expected 00007fff", rd); end
  endtask

  task automatic test_misaligned();
    int rc, ns, sc; logic [31:0] rd, sw, sa, exp_d; logic re, sww, ra; logic [3:0] sm; bit e;
    e = model_err(2'd2, 32'h05);
    exp_d = e ? 32'h0 : model_load(ref_mem[1], 32'h05, 2'd2, 1'b0);
    run_access(1'b0, 32'h05, 2'd2, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rc !== (e ? 1 : 3)) begin errors++; $display("[TB] FAIL misw resp cycle: got %0d expected %0d", rc, e ? 1 : 3); end
    checks++; if (re !== e) begin errors++; $display("[TB] FAIL misw error: got %b expected %b", re, e); end
    checks++; if (ns !== (e ? 0 : 1)) begin errors++; $display("[TB] FAIL misw strobes: got %0d expected %0d", ns, e ? 0 : 1); end
    checks++; if (rd !== exp_d) begin errors++; $display("[TB] FAIL misw data: got %h expected %h", rd, exp_d); end
    e = model_err(2'd1, 32'h03);
    exp_d = e ? 32'h0 : model_load(ref_mem[0], 32'h03, 2'd1, 1'b1);
    run_access(1'b0, 32'h03, 2'd1, 1'b1, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if ({re, rd} !== {e, exp_d}) begin errors++; $display("[TB] FAIL mish err/data: got %b/%h expected %b/%h", re, rd, e, exp_d); end
  endtask

  task automatic test_illegal_size();
    int rc, ns, sc; logic [31:0] rd, sw, sa; logic re, sww, ra; logic [3:0] sm;
    for (int w = 0; w < 2; w++) begin
      run_access(1'(w), 32'h40, 2'd3, 1'b0, 32'h12345678, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
      checks++; if ({rc, re, ns} !== {32'sd1, 1'b1, 32'sd0}) begin errors++; $display("[TB] FAIL size11 w=%0d: got cycle %0d err=%b strobes=%0d expected 1/1/0", w, rc, re, ns); end
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL size11 rdata w=%0d: got %h expected 0", w, rd); end
    end
  endtask

  task automatic test_timeout();
    int rc, ns, sc; logic [31:0] rd, sw, sa, exp_d; logic re, sww, ra; logic [3:0] sm;
    run_access(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 0, 1'b1, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if (rc !== TO + 2) begin errors++; $display("[TB] FAIL timeout cycle: got %0d expected %0d", rc, TO + 2); end
    checks++; if ({re, rd} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL timeout err/data: got %b/%h expected 1/00000000", re, rd); end
    checks++; if (ns !== 1) begin errors++; $display("[TB] FAIL timeout strobes: got %0d expected 1", ns); end
    exp_d = model_load(ref_mem[13], 32'h34, 2'd2, 1'b0);
    run_access(1'b0, 32'h34, 2'd2, 1'b0, 32'h0, 2, 1'b1, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if ({rc, re, rd} !== {32'sd4, 1'b0, exp_d}) begin errors++; $display("[TB] FAIL stale done: got cycle %0d err=%b data=%h expected 4/0/%h", rc, re, rd, exp_d); end
  endtask

  task automatic test_reset_midflight();
    int rc, ns, sc; logic [31:0] rd, sw, sa, exp_d; logic re, sww, ra; logic [3:0] sm; logic saw;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_size = 2'd2;
    req_unsigned = 1'b0; mem_done = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    checks++; if (mem_rstrobe !== 1'b1) begin errors++; $display("[TB] FAIL midrst strobe: got %b expected 1", mem_rstrobe); end
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({req_ready, mem_rstrobe, mem_wstrobe, resp_valid} !== 4'b1000) begin errors++; $display("[TB] FAIL midrst state: got %b expected 1000", {req_ready, mem_rstrobe, mem_wstrobe, resp_valid}); end
    rst = 1'b0; saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_done = 1'($urandom);
      @(posedge clk); #1;
      saw = saw | resp_valid;
    end
    mem_done = 1'b0;
    checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL midrst dropped resp: got %b expected 0", saw); end
    exp_d = model_load(ref_mem[16], 32'h40, 2'd2, 1'b0);
    run_access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1, 1'b0, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
    checks++; if ({rc, re, rd} !== {32'sd3, 1'b0, exp_d}) begin errors++; $display("[TB] FAIL midrst recovery: got cycle %0d err=%b data=%h expected 3/0/%h", rc, re, rd, exp_d); end
  endtask

  task automatic test_random();
    int rc, ns, sc, lat, exp_rc; logic [31:0] rd, sw, sa, a, wd, exp_d; logic re, sww, ra, wr, un;
    logic [3:0] sm; logic [1:0] sz; bit e, st; int r; int bad;
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom); a = $urandom % 256; r = int'($urandom % 10);
      sz = (r == 0) ? 2'd3 : 2'(r % 3); un = 1'($urandom); wd = $urandom;
      lat = int'($urandom_range(1, 3)); st = 1'($urandom);
      e = model_err(sz, a);
      exp_rc = e ? 1 : 2 + lat;
      exp_d = (e || wr) ? 32'h0 : model_load(ref_mem[a[7:2]], a, sz, un);
      run_access(wr, a, sz, un, wd, lat, st, rc, rd, re, ns, sc, sww, sm, sw, sa, ra);
      checks++; if ({rc, re} !== {exp_rc, e}) begin errors++; $display("[TB] FAIL rand%0d resp: got cycle %0d err=%b expected %0d/%b", i, rc, re, exp_rc, e); end
      checks++; if (rd !== exp_d) begin errors++; $display("[TB] FAIL rand%0d rdata: got %h expected %h", i, rd, exp_d); end
      checks++; if (ns !== (e ? 0 : 1)) begin errors++; $display("[TB] FAIL rand%0d strobes: got %0d expected %0d", i, ns, e ? 0 : 1); end
      checks++; if (ra !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d ready after resp: got %b expected 1", i, ra); end
      if (!e) begin
        checks++; if ({sc, sww, sa} !== {32'sd1, wr, a & ~32'h3}) begin errors++; $display("[TB] FAIL rand%0d strobe: got cycle %0d w=%b addr=%h expected 1/%b/%h", i, sc, sww, sa, wr, a & ~32'h3); end
        checks++; if (sm !== (wr ? model_mask(sz, a) : 4'b0)) begin errors++; $display("[TB] FAIL rand%0d mask: got %b expected %b", i, sm, wr ? model_mask(sz, a) : 4'b0); end
        if (wr) begin
          checks++; if (sw !== model_wdata(sz, wd)) begin errors++; $display("[TB] FAIL rand%0d wdata: got %h expected %h", i, sw, model_wdata(sz, wd)); end
          model_store(a, sz, wd);
        end
      end
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (bus_mem[k] !== ref_mem[k]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL memory image: got %0d differing words expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bus_mem[k] = $urandom;
      ref_mem[k] = bus_mem[k];
    end
    test_reset();
    test_directed();
    test_misaligned();
    test_illegal_size();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
